// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: ALU op codes common with the decoder,
// FSM state encodings and the iteration count.
package muldiv_unit_pkg;

   localparam logic [3:0] ALU_OP_MULT  = 4'hA;
   localparam logic [3:0] ALU_OP_MULTU = 4'hB;
   localparam logic [3:0] ALU_OP_DIV   = 4'hC;
   localparam logic [3:0] ALU_OP_DIVU  = 4'hD;

   localparam int unsigned MULDIV_ITERS = 32;

   typedef enum logic [2:0] {
      MULDIV_ST_IDLE = 3'd0,
      MULDIV_ST_MUL  = 3'd1,
      MULDIV_ST_DIV  = 3'd2,
      MULDIV_ST_FIX  = 3'd3,
      MULDIV_ST_DONE = 3'd4
   } muldiv_state_e;

   function automatic logic is_muldiv_op(input logic [3:0] op);
      return op inside {ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate; yields magnitudes at accept and
// applies result sign correction in FIX.
module muldiv_signfix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with HI/LO registers (IDLE -> MUL|DIV -> FIX -> DONE).
// Define MULDIV_FAST_MUL_EN to compute mult/multu in one cycle with a single multiplier.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   muldiv_state_e     state;
   logic [5:0]        cnt;
   logic [XLEN-1:0]   opnd;       // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
   logic              is_div;
   logic              neg_res;
   logic              neg_rem;
   logic              div_zero;

   logic              signed_op, op_div, accept;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;

   assign signed_op = (alu_op == ALU_OP_MULT) || (alu_op == ALU_OP_DIV);
   assign op_div    = (alu_op == ALU_OP_DIV) || (alu_op == ALU_OP_DIVU);
   assign a_neg     = signed_op & op_a[XLEN-1];
   assign b_neg     = signed_op & op_b[XLEN-1];
   assign accept    = (state == MULDIV_ST_IDLE) && start && is_muldiv_op(alu_op);

   muldiv_signfix #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(a_neg), .res_o(a_mag));
   muldiv_signfix #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(b_neg), .res_o(b_mag));

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod;

   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // Shifted remainder is below 2*divisor, so an XLEN-bit wrapped difference is exact when taken.
   assign div_ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, opnd};
   assign div_diff = acc[2*XLEN-2:XLEN-1] - opnd;
   assign div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
   assign prod = {{XLEN{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
`else
   assign prod = acc;
`endif

   logic [2*XLEN-1:0] res_fix;
   logic [XLEN-1:0]   rem_fix;

   muldiv_signfix #(.W(2*XLEN)) u_fix_res (
      .val_i (is_div ? {{XLEN{1'b0}}, acc[XLEN-1:0]} : prod),
      .neg_i (neg_res),
      .res_o (res_fix)
   );
   muldiv_signfix #(.W(XLEN)) u_fix_rem (
      .val_i (acc[2*XLEN-1:XLEN]),
      .neg_i (neg_rem),
      .res_o (rem_fix)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= MULDIV_ST_IDLE;
         cnt      <= '0;
         opnd     <= '0;
         acc      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         unique case (state)
            MULDIV_ST_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  is_div   <= op_div;
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= (op_b == '0);
                  if (op_div) begin
                     opnd  <= b_mag;
                     acc   <= {{XLEN{1'b0}}, a_mag};
                     state <= MULDIV_ST_DIV;
                  end else begin
                     opnd  <= a_mag;
                     acc   <= {{XLEN{1'b0}}, b_mag};
`ifdef MULDIV_FAST_MUL_EN
                     state <= MULDIV_ST_FIX;
`else
                     state <= MULDIV_ST_MUL;
`endif
                  end
               end
            end
            MULDIV_ST_MUL, MULDIV_ST_DIV: begin
               acc <= (state == MULDIV_ST_DIV) ? div_next : mul_next;
               if (cnt == 6'(MULDIV_ITERS - 1)) begin
                  cnt   <= '0;
                  state <= MULDIV_ST_FIX;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            MULDIV_ST_FIX: begin
               hi    <= is_div ? rem_fix : res_fix[2*XLEN-1:XLEN];
               // Divide by zero yields all-ones quotient regardless of operand signs.
               lo    <= (is_div && div_zero) ? '1 : res_fix[XLEN-1:0];
               done  <= 1'b1;
               state <= MULDIV_ST_DONE;
            end
            MULDIV_ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= MULDIV_ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= MULDIV_ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an
// arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  alu_op = 4'h0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_assert = 0;
   int n_fail   = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .alu_op (alu_op),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (op == ALU_OP_MULT) return 64'(sa * sb);
      if (op == ALU_OP_MULTU) return ua * ub;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == ALU_OP_DIV) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {32'(ua % ub), 32'(ua / ub)};
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
`ifdef MULDIV_FAST_MUL_EN
      if (op == ALU_OP_MULT || op == ALU_OP_MULTU) return 1;
`endif
      return 33;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      alu_op = op;
      op_a   = a;
      op_b   = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      alu_op = 4'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
   endtask

   task automatic wait_done(input int elapsed, input int lat, input logic [63:0] exp,
                            input string tag);
      int seen;
      seen = -1;
      for (int i = elapsed + 1; i <= 45 && seen < 0; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen = i;
      end
      chk(64'(seen), 64'(lat), {tag, ".latency"});
      chk({hi, lo}, exp, {tag, ".hilo"});
      chk({63'b0, busy}, 64'd1, {tag, ".busy_in_done"});
      @(posedge clk);
      #1;
      chk({63'b0, done}, 64'd0, {tag, ".done_pulse"});
      chk({63'b0, busy}, 64'd0, {tag, ".busy_end"});
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      issue(op, a, b);
      chk({63'b0, busy}, 64'd1, {tag, ".busy_start"});
      wait_done(0, exp_lat(op), model(op, a, b), tag);
   endtask

   initial begin
      logic [3:0]  codes [4];
      logic [63:0] exp1, held;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      int          pulses;
      codes = '{ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk({63'b0, busy}, 64'd0, "reset.busy");
      chk({63'b0, done}, 64'd0, "reset.done");
      chk({hi, lo}, 64'd0, "reset.hilo");

      run_op(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(ALU_OP_MULT, -32'sd3, 32'd7, "mult_neg");
      run_op(ALU_OP_DIV, -32'sd7, 32'd2, "div_neg");
      run_op(ALU_OP_DIVU, 32'd100, 32'd7, "divu");
      run_op(ALU_OP_DIVU, 32'd5, 32'd0, "divu_zero");
      run_op(ALU_OP_DIV, -32'sd5, 32'd0, "div_zero_neg");
      run_op(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(ALU_OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
      run_op(ALU_OP_DIV, 32'd9, -32'sd4, "div_negb");

      // Unsupported op code must be ignored.
      held = {hi, lo};
      issue(4'h3, 32'd12, 32'd3);
      chk({63'b0, busy}, 64'd0, "badop.busy");
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      chk(64'(pulses), 64'd0, "badop.no_done");
      chk({hi, lo}, held, "badop.hilo");

      // Second start while busy is dropped.
      exp1 = model(ALU_OP_DIVU, 32'd1000, 32'd33);
      issue(ALU_OP_DIVU, 32'd1000, 32'd33);
      repeat (9) @(posedge clk);
      @(negedge clk);
      start  = 1'b1;
      alu_op = ALU_OP_MULTU;
      op_a   = 32'd77;
      op_b   = 32'd88;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wait_done(10, 33, exp1, "restart_ignored");

      // Reset mid-operation aborts without writing HI/LO.
      issue(ALU_OP_DIV, 32'd12345, 32'd11);
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk({63'b0, busy}, 64'd0, "midrst.busy");
      chk({hi, lo}, 64'd0, "midrst.hilo");
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      chk(64'(pulses), 64'd0, "midrst.no_done");
      chk({hi, lo}, 64'd0, "midrst.hilo_held");
      run_op(ALU_OP_MULT, 32'd6, -32'sd9, "after_rst");

      // Start and reset on the same edge: reset wins.
      @(negedge clk);
      rst    = 1'b1;
      start  = 1'b1;
      alu_op = ALU_OP_DIVU;
      op_a   = 32'd50;
      op_b   = 32'd3;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      chk({63'b0, busy}, 64'd0, "rst_start.busy");
      chk({hi, lo}, 64'd0, "rst_start.hilo");

      for (int n = 0; n < 16; n++) begin
         rop = codes[$urandom_range(0, 3)];
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op(rop, ra, rb, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
